// File: rtl/ethernet_rx_packet_tracker_if.sv
// rtl/ethernet_rx_packet_tracker_if.sv - MAC write-side handshake between RX MAC and packet tracker
interface ethernet_rx_packet_tracker_if #(
  parameter int els_p       = 4,
  parameter int len_width_p = 11
);
  localparam int ptr_w_lp = $clog2(els_p);

  logic                   rx_done_v;
  logic [len_width_p-1:0] rx_done_len;
  logic                   rx_done_err;
  logic [ptr_w_lp-1:0]    rx_tail_slot;
  logic                   slot_free;

  modport master (
    output rx_done_v, rx_done_len, rx_done_err,
    input  rx_tail_slot, slot_free
  );

  modport slave (
    input  rx_done_v, rx_done_len, rx_done_err,
    output rx_tail_slot, slot_free
  );
endinterface

// File: rtl/ethernet_rx_packet_tracker.sv
// rtl/ethernet_rx_packet_tracker.sv - RX frame descriptor FIFO with drop counting for the ICU pending line
module ethernet_rx_packet_tracker #(
  parameter int els_p            = 4,
  parameter int len_width_p      = 11,
  parameter int drop_cnt_width_p = 16
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  ethernet_rx_packet_tracker_if.slave   mac_if,
  input  logic                          pop_v_i,
  input  logic                          drop_cnt_clear_i,
  output logic                          packet_avail_o,
  output logic [len_width_p-1:0]        head_len_o,
  output logic [$clog2(els_p)-1:0]      rx_head_slot_o,
  output logic [$clog2(els_p+1)-1:0]    count_o,
  output logic [drop_cnt_width_p-1:0]   drop_cnt_o,
  output logic                          overflow_o
);
  localparam int ptr_w_lp = $clog2(els_p);
  localparam int cnt_w_lp = $clog2(els_p+1);

  logic [len_width_p-1:0]      mem_q [els_p];
  logic [ptr_w_lp-1:0]         head_q, head_d, tail_q, tail_d;
  logic [cnt_w_lp-1:0]         count_q, count_d;
  logic [drop_cnt_width_p-1:0] drop_cnt_q, drop_cnt_d, drop_base;
  logic                        overflow_q, overflow_d, overflow_base;
  logic                        full, pop_eff, accept, drop;

  always_comb begin
    full          = (count_q == cnt_w_lp'(els_p));
    pop_eff       = pop_v_i & (count_q != '0);
    // A same-cycle pop frees the slot this edge, so a full tracker can still accept
    accept        = mac_if.rx_done_v & ~mac_if.rx_done_err &
                    (mac_if.rx_done_len != '0) & (~full | pop_eff);
    drop          = mac_if.rx_done_v & ~accept;

    head_d        = pop_eff ? head_q + ptr_w_lp'(1) : head_q;
    tail_d        = accept  ? tail_q + ptr_w_lp'(1) : tail_q;
    count_d       = count_q;
    if (accept && !pop_eff) count_d = count_q + cnt_w_lp'(1);
    if (!accept && pop_eff) count_d = count_q - cnt_w_lp'(1);

    drop_base     = drop_cnt_clear_i ? '0   : drop_cnt_q;
    overflow_base = drop_cnt_clear_i ? 1'b0 : overflow_q;
    drop_cnt_d    = drop_base;
    overflow_d    = overflow_base;
    if (drop) begin
      drop_cnt_d = (&drop_base) ? drop_base : drop_base + drop_cnt_width_p'(1);
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      drop_cnt_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      drop_cnt_q <= drop_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept && !reset_i) mem_q[tail_q] <= mac_if.rx_done_len;
  end

  assign packet_avail_o      = (count_q != '0);
  assign head_len_o          = packet_avail_o ? mem_q[head_q] : '0;
  assign rx_head_slot_o      = head_q;
  assign count_o             = count_q;
  assign drop_cnt_o          = drop_cnt_q;
  assign overflow_o          = overflow_q;
  assign mac_if.rx_tail_slot = tail_q;
  assign mac_if.slot_free    = ~full;
endmodule

// File: tb/tb_ethernet_rx_packet_tracker.sv
// tb/tb_ethernet_rx_packet_tracker.sv - scoreboard bench for ethernet_rx_packet_tracker
module tb_ethernet_rx_packet_tracker;
  localparam int EL = 4;
  localparam int LW = 11;
  localparam int DW = 4;   // narrow drop counter so saturation is reachable in a few drops
  localparam int DMAX = (1 << DW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pop_v = 1'b0;
  logic clr = 1'b0;
  logic           avail;
  logic [LW-1:0]  hlen;
  logic [1:0]     hslot;
  logic [2:0]     cnt;
  logic [DW-1:0]  dcnt;
  logic           ovf;

  ethernet_rx_packet_tracker_if #(.els_p(EL), .len_width_p(LW)) mac_if ();

  ethernet_rx_packet_tracker #(.els_p(EL), .len_width_p(LW), .drop_cnt_width_p(DW)) dut (
    .clk_i(clk), .reset_i(rst), .mac_if(mac_if), .pop_v_i(pop_v), .drop_cnt_clear_i(clr),
    .packet_avail_o(avail), .head_len_o(hlen), .rx_head_slot_o(hslot), .count_o(cnt),
    .drop_cnt_o(dcnt), .overflow_o(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int avail; int hlen; int hslot; int tslot; int sfree; int cnt; int dcnt; int ovf;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  int m_q[$];
  int m_head, m_tail, m_dc, m_ovf;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_head = 0; m_tail = 0; m_dc = 0; m_ovf = 0;
  endfunction

  function automatic void model_update(input int v, input int len, input int err,
                                       input int pop, input int cl);
    int pe, acc;
    pe  = (pop != 0) && (m_q.size() != 0);
    acc = (v != 0) && (err == 0) && (len != 0) && ((m_q.size() < EL) || pe);
    if (pe) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % EL;
    end
    if (acc) begin
      m_q.push_back(len);
      m_tail = (m_tail + 1) % EL;
    end
    if (cl != 0) begin m_dc = 0; m_ovf = 0; end
    if ((v != 0) && !acc) begin
      if (m_dc < DMAX) m_dc++;
      m_ovf = 1;
    end
  endfunction

  function automatic exp_t model_out();
    exp_t e;
    e.avail = (m_q.size() != 0);
    e.hlen  = (m_q.size() != 0) ? m_q[0] : 0;
    e.hslot = m_head;
    e.tslot = m_tail;
    e.sfree = (m_q.size() != EL);
    e.cnt   = m_q.size();
    e.dcnt  = m_dc;
    e.ovf   = m_ovf;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst && sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("sb_avail", int'(avail), e.avail);
      chk("sb_head_len", int'(hlen), e.hlen);
      chk("sb_head_slot", int'(hslot), e.hslot);
      chk("sb_tail_slot", int'(mac_if.rx_tail_slot), e.tslot);
      chk("sb_slot_free", int'(mac_if.slot_free), e.sfree);
      chk("sb_count", int'(cnt), e.cnt);
      chk("sb_drop_cnt", int'(dcnt), e.dcnt);
      chk("sb_overflow", int'(ovf), e.ovf);
    end
  end

  task automatic step(input int v, input int len, input int err, input int pop, input int cl);
    mac_if.rx_done_v   = v[0];
    mac_if.rx_done_len = len[LW-1:0];
    mac_if.rx_done_err = err[0];
    pop_v = pop[0];
    clr   = cl[0];
    @(posedge clk);
    if (!rst) model_update(v, len, err, pop, cl);
    #1;
    mac_if.rx_done_v = 1'b0; mac_if.rx_done_len = '0; mac_if.rx_done_err = 1'b0;
    pop_v = 1'b0; clr = 1'b0;
    if (!rst) sb_q.push_back(model_out());
  endtask

  task automatic reset_outputs_chk(input string tag);
    chk({tag, "_avail"}, int'(avail), 0);
    chk({tag, "_head_len"}, int'(hlen), 0);
    chk({tag, "_slot_free"}, int'(mac_if.slot_free), 1);
    chk({tag, "_count"}, int'(cnt), 0);
    chk({tag, "_drop_cnt"}, int'(dcnt), 0);
    chk({tag, "_overflow"}, int'(ovf), 0);
  endtask

  initial begin
    mac_if.rx_done_v = 1'b0; mac_if.rx_done_len = '0; mac_if.rx_done_err = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 reset_outputs_chk("rst_init");
    @(negedge clk); rst = 1'b0;

    // 1: single frame
    step(1, 64, 0, 0, 0);
    @(negedge clk);
    chk("t1_avail", int'(avail), 1);
    chk("t1_head_len", int'(hlen), 64);
    chk("t1_count", int'(cnt), 1);
    chk("t1_tail", int'(mac_if.rx_tail_slot), 1);
    step(0, 0, 0, 1, 0);

    // 2: fill, then drop on full
    for (int i = 60; i < 64; i++) step(1, i, 0, 0, 0);
    @(negedge clk);
    chk("t2_count", int'(cnt), 4);
    chk("t2_slot_free", int'(mac_if.slot_free), 0);
    step(1, 99, 0, 0, 0);
    @(negedge clk);
    chk("t2_drop_cnt", int'(dcnt), 1);
    chk("t2_overflow", int'(ovf), 1);
    chk("t2_head_len", int'(hlen), 60);

    // 3: full with same-cycle pop accepts
    step(1, 99, 0, 1, 0);
    @(negedge clk);
    chk("t3_count", int'(cnt), 4);
    chk("t3_head_len", int'(hlen), 61);
    chk("t3_drop_cnt", int'(dcnt), 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t3_reused_slot_len", int'(hlen), 99);
    chk("t3_reused_slot_idx", int'(hslot), 1);
    step(0, 0, 0, 1, 0);

    // 4: error and zero-length drops, pop on empty
    step(1, 50, 1, 0, 0);
    step(1, 0, 0, 0, 0);
    @(negedge clk);
    chk("t4_count", int'(cnt), 0);
    chk("t4_drop_cnt", int'(dcnt), 3);
    step(0, 0, 0, 1, 0);
    @(negedge clk);
    chk("t4_head_slot", int'(hslot), 2);
    chk("t4_tail_slot", int'(mac_if.rx_tail_slot), 2);

    // 5: streaming push/pop across pointer wrap
    step(1, 100, 0, 0, 0);
    for (int i = 1; i <= 8; i++) begin
      step(1, 100 + i, 0, 1, 0);
      @(negedge clk);
      chk("t5_head_len", int'(hlen), 100 + i);
    end
    step(0, 0, 0, 1, 0);

    // 6: drop counter saturation and clear ordering
    step(0, 0, 0, 0, 1);
    @(negedge clk);
    chk("t6_clr_drop", int'(dcnt), 0);
    chk("t6_clr_ovf", int'(ovf), 0);
    for (int i = 0; i < DMAX; i++) step(1, 7, 1, 0, 0);
    @(negedge clk);
    chk("t6_sat", int'(dcnt), DMAX);
    step(1, 7, 1, 0, 0);
    @(negedge clk);
    chk("t6_sat_hold", int'(dcnt), DMAX);
    step(1, 5, 1, 0, 1);
    @(negedge clk);
    chk("t6_clr_and_drop", int'(dcnt), 1);
    chk("t6_clr_and_drop_ovf", int'(ovf), 1);
    step(0, 0, 0, 0, 1);

    // 7: asynchronous reset mid-stream
    for (int i = 10; i < 13; i++) step(1, i, 0, 0, 0);
    @(negedge clk);
    chk("t7_pre_count", int'(cnt), 3);
    #1 rst = 1'b1;
    #1 reset_outputs_chk("t7_async");
    sb_q.delete();
    model_reset();
    step(1, 77, 0, 0, 0);
    @(negedge clk);
    chk("t7_pulse_ignored", int'(cnt), 0);
    rst = 1'b0;
    step(1, 33, 0, 0, 0);
    step(0, 0, 0, 1, 0);

    begin
      int budget = 20;
      while (sb_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      chk("sb_drained", sb_q.size(), 0);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
